// File: rtl/fp32_accumulator.sv
// fp32_accumulator: multi-cycle FP32 running-sum accumulator (align, add, normalize, truncating)
module fp32_accumulator #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clear,
  output logic [31:0]        acc_out,
  output logic               sum_valid,
  output logic [COUNT_W-1:0] term_count,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;
  state_t r_state;
  logic [31:0] r_acc, r_op;
  logic [26:0] r_ma, r_mb;
  logic [27:0] r_sum;
  logic [7:0] r_exp;
  logic r_sa, r_sb, r_sign, r_nan, r_inf, r_inf_s, r_sv, r_ovf;
  logic [COUNT_W-1:0] r_cnt;
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) lzc27 = 5'(26 - i);
  endfunction
  logic [7:0] w_ea, w_eb, w_diff;
  logic [26:0] w_ma_x, w_mb_x, w_small, w_shifted;
  logic w_a_big, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_nan, w_inf, w_inf_s;
  logic w_mag_ge, w_sign, w_zero, w_ovf;
  logic [27:0] w_sum;
  logic [4:0] w_lz;
  logic signed [9:0] w_exp_n;
  logic [22:0] w_frac;
  logic [31:0] w_result;
  // Align: decode both operands, pick the larger exponent, shift the other mantissa right
  always_comb begin
    w_ea = r_acc[30:23];
    w_eb = r_op[30:23];
    w_a_nan = (&w_ea) && (|r_acc[22:0]);
    w_b_nan = (&w_eb) && (|r_op[22:0]);
    w_a_inf = (&w_ea) && !(|r_acc[22:0]);
    w_b_inf = (&w_eb) && !(|r_op[22:0]);
    w_ma_x = (w_ea == 8'd0) ? 27'd0 : {1'b1, r_acc[22:0], 3'b000};
    w_mb_x = (w_eb == 8'd0) ? 27'd0 : {1'b1, r_op[22:0], 3'b000};
    w_a_big = w_ea >= w_eb;
    w_diff = w_a_big ? w_ea - w_eb : w_eb - w_ea;
    w_small = w_a_big ? w_mb_x : w_ma_x;
    w_shifted = (w_diff >= 8'd27) ? 27'd0 : w_small >> w_diff;
    w_nan = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_acc[31] != r_op[31]));
    w_inf = w_a_inf || w_b_inf;
    w_inf_s = w_a_inf ? r_acc[31] : r_op[31];
  end
  // Add: signed-magnitude sum; on differing signs the larger magnitude sets the sign
  always_comb begin
    w_mag_ge = r_ma >= r_mb;
    w_sum = (r_sa == r_sb) ? {1'b0, r_ma} + {1'b0, r_mb} : w_mag_ge ? {1'b0, r_ma - r_mb} : {1'b0, r_mb - r_ma};
    w_sign = (r_sa == r_sb || w_mag_ge) ? r_sa : r_sb;
  end
  // Normalize: carry shifts right, otherwise leading-zero shift left; truncate guard bits
  always_comb begin
    w_lz = lzc27(r_sum[26:0]);
    w_exp_n = r_sum[27] ? {2'b00, r_exp} + 10'd1 : {2'b00, r_exp} - {5'b00000, w_lz};
    w_frac = r_sum[27] ? r_sum[26:4] : 23'((r_sum[26:0] << w_lz) >> 3);
    w_zero = r_sum == 28'd0;
    w_ovf = !r_nan && !r_inf && !w_zero && (w_exp_n >= 10'sd255);
    w_result = r_nan ? 32'h7FC00000 : r_inf ? {r_inf_s, 31'h7F800000} :
               (w_zero || w_exp_n <= 10'sd0) ? 32'd0 :
               w_ovf ? {r_sign, 31'h7F800000} : {r_sign, w_exp_n[7:0], w_frac};
  end
  // Control FSM and datapath registers; clear wins over any in-flight step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_op <= '0;
      r_ma <= '0;
      r_mb <= '0;
      r_sum <= '0;
      r_exp <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_sign <= 1'b0;
      r_nan <= 1'b0;
      r_inf <= 1'b0;
      r_inf_s <= 1'b0;
      r_sv <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sv <= 1'b0;
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_state <= (r_state == IDLE && in_valid) ? ALIGN : IDLE;
        if (r_state == IDLE && in_valid) r_op <= in_data;
      end else begin
        case (r_state)
          IDLE: if (in_valid) begin
            r_op <= in_data;
            r_state <= ALIGN;
          end
          ALIGN: begin
            r_ma <= w_a_big ? w_ma_x : w_mb_x;
            r_mb <= w_shifted;
            r_sa <= w_a_big ? r_acc[31] : r_op[31];
            r_sb <= w_a_big ? r_op[31] : r_acc[31];
            r_exp <= w_a_big ? w_ea : w_eb;
            r_nan <= w_nan;
            r_inf <= w_inf;
            r_inf_s <= w_inf_s;
            r_state <= ADD;
          end
          ADD: begin
            r_sum <= w_sum;
            r_sign <= w_sign;
            r_state <= NORM;
          end
          default: begin
            r_acc <= w_result;
            r_sv <= 1'b1;
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            r_ovf <= r_ovf | w_ovf;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
  assign in_ready = r_state == IDLE;
  assign acc_out = r_acc;
  assign sum_valid = r_sv;
  assign term_count = r_cnt;
  assign overflow = r_ovf;
endmodule

// File: doc/fp32_accumulator.md
Name:
fp32_accumulator

Overview:
- Downstream consumer of the FP32 `multiplier` block: takes each IEEE-754 single-precision product (`result`/`valid`) and adds it into a running FP32 sum.
- Forms the accumulate half of the team's multiply-accumulate datapath.
- Multi-cycle FSM: align, add, normalize. Fixed latency, with an in_ready/in_valid handshake toward the multiplier.

Parameters:
- COUNT_W, 16, width of the saturating term counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- in_data  input  32  FP32 operand (multiplier result).
- in_valid  input  1  in_data valid; upstream holds in_data stable until accepted.
- in_ready  output  1  block can accept an operand this cycle.
- clear  input  1  synchronous accumulator clear.
- acc_out  output  32  current FP32 accumulated sum.
- sum_valid  output  1  one-cycle pulse when acc_out has been updated.
- term_count  output  COUNT_W  terms accumulated since last clear; saturates at all-ones.
- overflow  output  1  sticky flag, set when a sum overflows to infinity.

Behaviour:
- Reset (rst=0, asynchronous):
  - acc_out=0x00000000, sum_valid=0, in_ready=1, term_count=0, overflow=0.
  - State goes to IDLE. Any in-flight operation is discarded.
- FSM states: IDLE, ALIGN, ADD, NORM.
  - Accept occurs at edge E0 when in_valid=1 and in_ready=1 in IDLE.
  - IDLE -> ALIGN at E0, ALIGN -> ADD at E1, ADD -> NORM at E2.
  - NORM -> IDLE at E3. At E3: acc_out updated, sum_valid=1 for the cycle after E3, term_count incremented.
- in_ready=1 only in IDLE. Throughput is one operand per 4 cycles. in_ready returns high the cycle after E3.
- Operand decode:
  - exp==0 is treated as ±0 (denormals flushed; frac ignored).
  - exp==255 with frac!=0 is NaN. exp==255 with frac==0 is ±Inf.
- ALIGN:
  - Mantissas extended to 27 bits: hidden 1, 23 frac, 3 guard.
  - The smaller-exponent operand is shifted right by the exponent difference. A shift of 27 or more makes that operand 0.
- ADD:
  - Same signs: magnitudes added, 28-bit result.
  - Different signs: smaller magnitude subtracted from larger; the result takes the sign of the larger.
- NORM:
  - Carry out: shift right 1, exp+1.
  - Otherwise: single-cycle leading-zero count, shift left, exp-lzc.
  - Exact zero result, or exp<=0 after normalization: +0.
  - exp>=255: ±Inf (0x7F800000 / 0xFF800000) and overflow<=1.
  - Rounding is truncation (round toward zero); guard bits are discarded.
- Special values:
  - Any NaN operand, or Inf + (-Inf), gives acc_out=0x7FC00000. NaN stays sticky until clear or reset.
  - Inf + finite gives Inf.
- A zero operand still increments term_count and pulses sum_valid.
- clear in IDLE:
  - Next edge: acc_out=0, term_count=0, overflow=0, no sum_valid.
  - If in_valid is also 1, the operand is accepted with the accumulator treated as +0. After E3: acc_out=normalized in_data, term_count=1.
- clear in ALIGN/ADD/NORM: aborts the operation. Next edge: acc_out=0, term_count=0, overflow=0, state=IDLE, no sum_valid.
- term_count saturates at 2^COUNT_W-1. Further accepts still update the sum.
- in_valid while busy is ignored (not accepted). The operand is taken on the first IDLE cycle if still valid.

Test Plan:
- Reset: hold rst=0 mid-operation -> immediately acc_out=0x00000000, sum_valid=0, in_ready=1, term_count=0, overflow=0.
- Accumulate 0x3F800000 (1.0), 0x40800000 (4.0), 0x41100000 (9.0) -> acc_out 0x3F800000, 0x40A00000, 0x41600000. Each sum_valid pulse comes 4 cycles after its accept. in_ready=0 for 3 cycles after each accept. term_count=3.
- Cancellation: clear, then 0x42C80000 (100.0), then 0xC2C80000 (-100.0) -> acc_out=0x00000000, term_count=2.
- Truncation/alignment: clear, 0x4B800000 (2^24) then 0x3F800000 (1.0) -> acc_out stays 0x4B800000.
- Overflow and NaN:
  - 0x7F000000 twice -> acc_out=0x7F800000, overflow=1.
  - Then 0x7FC00000 -> 0x7FC00000; a further 0x3F800000 keeps 0x7FC00000.
  - Then clear -> 0x00000000, overflow=0.
- Clear mid-op: accept 0x40000000 (2.0), assert clear in ADD -> no sum_valid, acc_out=0, in_ready=1 on the next cycle. clear+in_valid(0x40400000) in IDLE -> acc_out=0x40400000, term_count=1.
